ahb_master: RTL and testbench

AHB-Lite single-transfer master between the socket's user request port (enable/wr/addr/data) and the AHB bus. It turns each accepted request into one NONSEQ SINGLE transfer. It overlaps a new address phase with the current data phase, stalls on HREADY and handles the two-cycle ERROR response. Read data returns to the user side with a valid pulse; writes report completion with a done pulse.

---
 rtl/ahb_master_if.sv | 26 ++
 rtl/ahb_master.sv | 183 ++++++++++++++++++
 tb/tb_ahb_master.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_master_if.sv
// AHB-Lite bus bundle between ahb_master and the slave mux.
// Master drives the address/control/write-data side; slave returns ready/resp/rdata.
interface ahb_master_if #(
  parameter int DATAWIDTH = 16,
  parameter int ADDRWIDTH = 6
);
  logic [ADDRWIDTH-1:0] haddr;
  logic [1:0]           htrans;
  logic                 hwrite;
  logic [2:0]           hsize;
  logic [2:0]           hburst;
  logic [DATAWIDTH-1:0] hwdata;
  logic                 hready;
  logic                 hresp;
  logic [DATAWIDTH-1:0] hrdata;

  modport master (
    output haddr, htrans, hwrite, hsize, hburst, hwdata,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  haddr, htrans, hwrite, hsize, hburst, hwdata,
    output hready, hresp, hrdata
  );
endinterface

// File: rtl/ahb_master.sv
// AHB-Lite single-transfer master: pipelined address/data slots, ERROR handling.
// Define AHB_MASTER_ERR_RETRY_EN to re-issue an address phase cancelled by ERROR.
module ahb_master #(
  parameter int DATAWIDTH = 16,
  parameter int ADDRWIDTH = 6
) (
  input  logic                 hclk,
  input  logic                 hrst,
  input  logic                 enable,
  input  logic                 wr,
  input  logic [ADDRWIDTH-1:0] addr_input,
  input  logic [DATAWIDTH-1:0] data_input,
  output logic                 req_ready,
  output logic [DATAWIDTH-1:0] data_output,
  output logic                 rd_valid,
  output logic                 wr_done,
  output logic                 err,
  ahb_master_if.master         bus
);

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_NONSEQ = 2'b10
  } htrans_e;

  localparam logic [2:0] HSIZE =
    (DATAWIDTH == 32) ? 3'd2 :
    (DATAWIDTH == 16) ? 3'd1 : 3'd0;

  // A slot: address/wr live in haddr_q/hwrite_q
  logic                 a_vld_q, a_vld_d;
  logic [DATAWIDTH-1:0] a_wdata_q, a_wdata_d;
  logic                 d_vld_q, d_vld_d;
  logic                 d_wr_q, d_wr_d;

  logic [ADDRWIDTH-1:0] haddr_q, haddr_d;
  htrans_e              htrans_q, htrans_d;
  logic                 hwrite_q, hwrite_d;
  logic [DATAWIDTH-1:0] hwdata_q, hwdata_d;

  logic [DATAWIDTH-1:0] rdata_q, rdata_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 wr_done_q, wr_done_d;
  logic                 err_q, err_d;

`ifdef AHB_MASTER_ERR_RETRY_EN
  logic                 hold_q, hold_d;
  logic                 reiss_q, reiss_d;
`endif

  logic accept;
  logic err_hit;

  always_comb begin
    req_ready = !hrst && !bus.hresp && (!a_vld_q || bus.hready);
`ifdef AHB_MASTER_ERR_RETRY_EN
    // a parked or re-issued address phase blocks new requests
    req_ready = req_ready && !hold_q && !reiss_q;
`endif
  end

  assign accept  = enable && req_ready;
  assign err_hit = d_vld_q && bus.hresp;

  always_comb begin
    a_vld_d    = a_vld_q;
    a_wdata_d  = a_wdata_q;
    d_vld_d    = d_vld_q;
    d_wr_d     = d_wr_q;
    haddr_d    = haddr_q;
    htrans_d   = htrans_q;
    hwrite_d   = hwrite_q;
    hwdata_d   = hwdata_q;
    rdata_d    = rdata_q;
    rd_valid_d = 1'b0;
    wr_done_d  = 1'b0;
    err_d      = 1'b0;
`ifdef AHB_MASTER_ERR_RETRY_EN
    hold_d     = hold_q;
    reiss_d    = reiss_q;
`endif

    if (err_hit) begin
      htrans_d = HT_IDLE;
      a_vld_d  = 1'b0;
`ifdef AHB_MASTER_ERR_RETRY_EN
      if (a_vld_q) hold_d = 1'b1;
`endif
      if (bus.hready) begin
        d_vld_d = 1'b0;
        err_d   = 1'b1;
`ifdef AHB_MASTER_ERR_RETRY_EN
        if (hold_q || a_vld_q) begin
          a_vld_d  = 1'b1;
          hold_d   = 1'b0;
          reiss_d  = 1'b1;
          htrans_d = HT_NONSEQ;
        end
`endif
      end
    end else begin
      if (bus.hready && d_vld_q) begin
        d_vld_d = 1'b0;
        if (d_wr_q) begin
          wr_done_d = 1'b1;
        end else begin
          rdata_d    = bus.hrdata;
          rd_valid_d = 1'b1;
        end
      end

      if (bus.hready && a_vld_q) begin
        d_vld_d  = 1'b1;
        d_wr_d   = hwrite_q;
        a_vld_d  = 1'b0;
        htrans_d = HT_IDLE;
        if (hwrite_q) hwdata_d = a_wdata_q;
`ifdef AHB_MASTER_ERR_RETRY_EN
        reiss_d  = 1'b0;
`endif
      end

      if (accept) begin
        a_vld_d   = 1'b1;
        a_wdata_d = data_input;
        haddr_d   = addr_input;
        hwrite_d  = wr;
        htrans_d  = HT_NONSEQ;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hrst) begin
      a_vld_q    <= 1'b0;
      a_wdata_q  <= '0;
      d_vld_q    <= 1'b0;
      d_wr_q     <= 1'b0;
      haddr_q    <= '0;
      htrans_q   <= HT_IDLE;
      hwrite_q   <= 1'b0;
      hwdata_q   <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
      err_q      <= 1'b0;
`ifdef AHB_MASTER_ERR_RETRY_EN
      hold_q     <= 1'b0;
      reiss_q    <= 1'b0;
`endif
    end else begin
      a_vld_q    <= a_vld_d;
      a_wdata_q  <= a_wdata_d;
      d_vld_q    <= d_vld_d;
      d_wr_q     <= d_wr_d;
      haddr_q    <= haddr_d;
      htrans_q   <= htrans_d;
      hwrite_q   <= hwrite_d;
      hwdata_q   <= hwdata_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
      wr_done_q  <= wr_done_d;
      err_q      <= err_d;
`ifdef AHB_MASTER_ERR_RETRY_EN
      hold_q     <= hold_d;
      reiss_q    <= reiss_d;
`endif
    end
  end

  assign bus.haddr   = haddr_q;
  assign bus.htrans  = htrans_q;
  assign bus.hwrite  = hwrite_q;
  assign bus.hsize   = HSIZE;
  assign bus.hburst  = 3'b000;
  assign bus.hwdata  = hwdata_q;

  assign data_output = rdata_q;
  assign rd_valid    = rd_valid_q;
  assign wr_done     = wr_done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ahb_master.sv
// Directed bench for ahb_master; expected responses queued at issue,
// checked by a negedge monitor against kind, cycle and read data.
module tb_ahb_master;
  localparam int DW = 16;
  localparam int AW = 6;
  localparam int K_RD = 0;
  localparam int K_WR = 1;
  localparam int K_ER = 2;

  logic          hclk = 1'b0;
  logic          hrst = 1'b1;
  logic          enable = 1'b0;
  logic          wr = 1'b0;
  logic [AW-1:0] addr_input = '0;
  logic [DW-1:0] data_input = '0;
  logic          req_ready;
  logic [DW-1:0] data_output;
  logic          rd_valid;
  logic          wr_done;
  logic          err;

  ahb_master_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus ();

  ahb_master #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .hclk       (hclk),
    .hrst       (hrst),
    .enable     (enable),
    .wr         (wr),
    .addr_input (addr_input),
    .data_input (data_input),
    .req_ready  (req_ready),
    .data_output(data_output),
    .rd_valid   (rd_valid),
    .wr_done    (wr_done),
    .err        (err),
    .bus        (bus)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    int          kind;
    logic [DW-1:0] data;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge hclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [DW-1:0] data,
                      input int at);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  exp_t mon_e;
  int   mon_k;

  always @(negedge hclk) begin
    if (rd_valid || wr_done || err) begin
      mon_k = rd_valid ? K_RD : (wr_done ? K_WR : K_ER);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse kind %0d at cyc %0d want none",
                 mon_k, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_kind", mon_k, mon_e.kind);
        chk("resp_cycle", cyc, mon_e.at);
        if (mon_e.kind == K_RD)
          chk("rd_data", {16'h0, data_output}, {16'h0, mon_e.data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d want finish", cyc);
    $fatal(1);
  end

  initial begin
    int e;
    logic [DW-1:0] wd [3];
    wd[0] = 16'h1111;
    wd[1] = 16'h2222;
    wd[2] = 16'h3333;
    bus.hready = 1'b1;
    bus.hresp  = 1'b0;
    bus.hrdata = '0;

    // reset state
    repeat (3) tick();
    @(negedge hclk);
    chk("rst_htrans", bus.htrans, 2'b00);
    chk("rst_haddr", bus.haddr, 0);
    chk("rst_hwrite", bus.hwrite, 0);
    chk("rst_hwdata", bus.hwdata, 0);
    chk("rst_dout", data_output, 0);
    chk("rst_ready", req_ready, 0);
    chk("hsize", bus.hsize, 3'd1);
    chk("hburst", bus.hburst, 3'd0);
    tick();
    hrst = 1'b0;
    @(negedge hclk);
    chk("ready_after_rst", req_ready, 1);
    tick();

    // write 0x1234 @0x0A then read it back, zero wait
    e = cyc + 1;
    enable = 1'b1; wr = 1'b1; addr_input = 6'h0A; data_input = 16'h1234;
    push(K_WR, '0, e + 2);
    tick();
    wr = 1'b0;
    push(K_RD, 16'h1234, e + 3);
    @(negedge hclk);
    chk("t1_htrans_c1", bus.htrans, 2'b10);
    chk("t1_haddr_c1", bus.haddr, 6'h0A);
    chk("t1_hwrite_c1", bus.hwrite, 1);
    tick();
    enable = 1'b0;
    @(negedge hclk);
    chk("t1_hwdata_c2", bus.hwdata, 16'h1234);
    chk("t1_rd_htrans", bus.htrans, 2'b10);
    chk("t1_rd_hwrite", bus.hwrite, 0);
    tick();
    bus.hrdata = 16'h1234;
    @(negedge hclk);
    chk("t1_idle", bus.htrans, 2'b00);
    tick();
    bus.hrdata = '0;
    repeat (2) tick();

    // read 0x04 with 3 data-phase waits, write 0x06 stuck in A
    e = cyc + 1;
    enable = 1'b1; wr = 1'b0; addr_input = 6'h04;
    push(K_RD, 16'hBEEF, e + 5);
    tick();
    wr = 1'b1; addr_input = 6'h06; data_input = 16'h5A5A;
    push(K_WR, '0, e + 6);
    @(negedge hclk);
    chk("t2_haddr", bus.haddr, 6'h04);
    tick();
    enable = 1'b0;
    bus.hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk);
      chk("t2_hold_htrans", bus.htrans, 2'b10);
      chk("t2_hold_haddr", bus.haddr, 6'h06);
      chk("t2_wait_ready", req_ready, 0);
      tick();
    end
    bus.hready = 1'b1;
    bus.hrdata = 16'hBEEF;
    @(negedge hclk);
    chk("t2_ready_rel", req_ready, 1);
    tick();
    bus.hrdata = '0;
    @(negedge hclk);
    chk("t2_hwdata", bus.hwdata, 16'h5A5A);
    chk("t2_idle", bus.htrans, 2'b00);
    repeat (3) tick();

    // three back-to-back writes
    for (int i = 0; i < 3; i++) begin
      e = cyc + 1;
      enable = 1'b1; wr = 1'b1;
      addr_input = AW'(2 * i);
      data_input = wd[i];
      push(K_WR, '0, e + 2);
      if (i > 0) begin
        @(negedge hclk);
        chk("t3_htrans", bus.htrans, 2'b10);
        chk("t3_haddr", bus.haddr, 32'(2 * (i - 1)));
        if (i > 1) chk("t3_hwdata", bus.hwdata, wd[i-2]);
      end
      tick();
    end
    enable = 1'b0;
    @(negedge hclk);
    chk("t3_haddr_last", bus.haddr, 6'h04);
    chk("t3_hwdata_1", bus.hwdata, wd[1]);
    tick();
    @(negedge hclk);
    chk("t3_idle", bus.htrans, 2'b00);
    chk("t3_hwdata_2", bus.hwdata, wd[2]);
    repeat (2) tick();

    // ERROR on read 0x10 with read 0x12 queued behind it
    e = cyc + 1;
    enable = 1'b1; wr = 1'b0; addr_input = 6'h10;
    push(K_ER, '0, e + 3);
    tick();
    addr_input = 6'h12;
`ifdef AHB_MASTER_ERR_RETRY_EN
    push(K_RD, 16'hCAFE, e + 5);
`endif
    @(negedge hclk);
    chk("t4_haddr10", bus.haddr, 6'h10);
    tick();
    enable = 1'b0;
    bus.hresp = 1'b1;
    bus.hready = 1'b0;
    @(negedge hclk);
    chk("t4_e1_ready", req_ready, 0);
    chk("t4_e1_haddr", bus.haddr, 6'h12);
    tick();
    bus.hready = 1'b1;
    @(negedge hclk);
    chk("t4_e2_idle", bus.htrans, 2'b00);
    chk("t4_e2_ready", req_ready, 0);
    tick();
    bus.hresp = 1'b0;
`ifdef AHB_MASTER_ERR_RETRY_EN
    @(negedge hclk);
    chk("t4_reissue", bus.htrans, 2'b10);
    chk("t4_reissue_addr", bus.haddr, 6'h12);
    chk("t4_reissue_ready", req_ready, 0);
    tick();
    bus.hrdata = 16'hCAFE;
    @(negedge hclk);
    chk("t4_retry_idle", bus.htrans, 2'b00);
    tick();
    bus.hrdata = '0;
`else
    @(negedge hclk);
    chk("t4_no_reissue", bus.htrans, 2'b00);
    chk("t4_ready_back", req_ready, 1);
    tick();
    @(negedge hclk);
    chk("t4_still_idle", bus.htrans, 2'b00);
    tick();
`endif
    repeat (2) tick();

    // reset during data phase of a read
    enable = 1'b1; wr = 1'b0; addr_input = 6'h08;
    tick();
    enable = 1'b0;
    tick();
    hrst = 1'b1;
    bus.hrdata = 16'h7777;
    @(negedge hclk);
    chk("t5_ready_in_rst", req_ready, 0);
    tick();
    @(negedge hclk);
    chk("t5_rst_htrans", bus.htrans, 2'b00);
    chk("t5_rst_dout", data_output, 0);
    chk("t5_rst_ready", req_ready, 0);
    tick();
    hrst = 1'b0;
    bus.hrdata = '0;
    @(negedge hclk);
    chk("t5_ready_rel", req_ready, 1);
    repeat (4) tick();

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
